// File: rtl/tx_sample_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tx_sample_packer
// Brief    : Host-side write stage for the TX FIFO: formats samples, enforces
//            L/R alternation, 2-word skid buffer. Option macro: MONO_DUP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tx_sample_packer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             wclk,
    input  logic             rst_,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_chan,
`ifdef MONO_DUP_EN
    input  logic             mono,
`endif
    input  logic             frame16,
    input  logic [1:0]       data_size,
    input  logic             stop,
    output logic [WIDTH-1:0] fifo_din,
    output logic             fifo_wr_en,
    input  logic             fifo_full,
    output logic             chan_err,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic CHAN_L = 1'b0;

    logic [WIDTH-1:0] mem0_q, mem0_d;
    logic [WIDTH-1:0] mem1_q, mem1_d;
    logic             wp_q, wp_d;
    logic             rp_q, rp_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             exp_q, exp_d;
    logic             chan_err_q, chan_err_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [WIDTH-1:0] w_just;
    logic [WIDTH-1:0] w_word;
    logic             w_accept;
    logic             w_match;
    logic             w_push;
    logic             w_drop;
    logic             w_dup;
    logic [1:0]       w_push_n;

    // Left-justify the DS-bit sample; a 16-bit frame keeps the top 16 bits of that.
    always_comb begin
        w_just = '0;
        case (data_size)
            2'b00:   w_just = s_data << (WIDTH - 8);
            2'b01:   w_just = s_data << (WIDTH - 16);
            2'b10:   w_just = s_data << (WIDTH - 24);
            default: w_just = s_data;
        endcase
        w_word = frame16 ? {{(WIDTH-16){1'b0}}, w_just[WIDTH-1 -: 16]} : w_just;
    end

`ifdef MONO_DUP_EN
    assign s_ready = (mono ? (cnt_q == 2'd0) : (cnt_q != 2'd2)) & ~stop;
    assign w_dup   = mono;
    assign w_match = mono | (s_chan == exp_q);
`else
    assign s_ready = (cnt_q != 2'd2) & ~stop;
    assign w_dup   = 1'b0;
    assign w_match = (s_chan == exp_q);
`endif

    assign w_accept   = s_valid & s_ready;
    assign w_push     = w_accept & w_match;
    assign w_drop     = w_accept & ~w_match;
    assign w_push_n   = w_push ? (w_dup ? 2'd2 : 2'd1) : 2'd0;

    assign fifo_wr_en = (cnt_q != 2'd0) & ~fifo_full & ~stop;
    assign fifo_din   = rp_q ? mem1_q : mem0_q;
    assign chan_err   = chan_err_q;
    assign drop_cnt   = drop_cnt_q;

    always_comb begin
        mem0_d     = mem0_q;
        mem1_d     = mem1_q;
        wp_d       = wp_q;
        rp_d       = rp_q;
        cnt_d      = cnt_q;
        exp_d      = exp_q;
        chan_err_d = chan_err_q;
        drop_cnt_d = drop_cnt_q;

        if (stop) begin
            wp_d  = 1'b0;
            rp_d  = 1'b0;
            cnt_d = 2'd0;
            exp_d = CHAN_L;
        end else begin
            if (fifo_wr_en) begin
                rp_d = ~rp_q;
            end
            if (w_push) begin
                // A mono duplicate fills both slots, so the write pointer wraps back.
                if (!wp_q || w_dup) begin
                    mem0_d = w_word;
                end
                if (wp_q || w_dup) begin
                    mem1_d = w_word;
                end
                if (!w_dup) begin
                    wp_d  = ~wp_q;
                    exp_d = ~exp_q;
                end
            end
            cnt_d = cnt_q + w_push_n - {1'b0, fifo_wr_en};
        end

        if (w_drop) begin
            chan_err_d = 1'b1;
            if (drop_cnt_q != {CNT_W{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            mem0_q     <= '0;
            mem1_q     <= '0;
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            cnt_q      <= 2'd0;
            exp_q      <= CHAN_L;
            chan_err_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            mem0_q     <= mem0_d;
            mem1_q     <= mem1_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            cnt_q      <= cnt_d;
            exp_q      <= exp_d;
            chan_err_q <= chan_err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_sample_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tx_sample_packer
// Brief    : Directed and randomized checks of tx_sample_packer against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_sample_packer;

    localparam int WIDTH   = 32;
    localparam int CNT_W   = 8;
    localparam int DROP_MX = (1 << CNT_W) - 1;

    logic             wclk = 1'b0;
    logic             rst_ = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [WIDTH-1:0] s_data = '0;
    logic             s_chan = 1'b0;
    logic             frame16 = 1'b1;
    logic [1:0]       data_size = 2'b01;
    logic             stop = 1'b0;
    logic [WIDTH-1:0] fifo_din;
    logic             fifo_wr_en;
    logic             fifo_full = 1'b0;
    logic             chan_err;
    logic [CNT_W-1:0] drop_cnt;
`ifdef MONO_DUP_EN
    logic             mono = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of pending words plus the channel/drop bookkeeping.
    logic [31:0] mq[$];
    bit          m_exp;
    bit          m_err;
    int          m_drops;

    tx_sample_packer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .wclk       (wclk),
        .rst_       (rst_),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_chan     (s_chan),
`ifdef MONO_DUP_EN
        .mono       (mono),
`endif
        .frame16    (frame16),
        .data_size  (data_size),
        .stop       (stop),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .fifo_full  (fifo_full),
        .chan_err   (chan_err),
        .drop_cnt   (drop_cnt)
    );

    always #5 wclk = ~wclk;

    function automatic logic [31:0] ref_fmt(logic [31:0] d, logic f16, logic [1:0] dsz);
        int ds;
        int eff;
        longint unsigned v;
        ds = (int'(dsz) + 1) * 8;
        v  = longint'(d) & ((64'd1 << ds) - 1);
        if (f16) begin
            eff = (ds < 16) ? ds : 16;
            v   = (v >> (ds - eff)) << (16 - eff);
        end else begin
            v = v << (32 - ds);
        end
        return v[31:0];
    endfunction

    task automatic model_reset();
        mq.delete();
        m_exp   = 1'b0;
        m_err   = 1'b0;
        m_drops = 0;
    endtask

    // One clock: the model consumes the inputs held across the edge, returns at negedge.
    task automatic tick();
        bit rdy;
        bit wr;
        @(posedge wclk);
        rdy = (mq.size() < 2) && !stop;
        wr  = (mq.size() > 0) && !fifo_full && !stop;
        if (stop) begin
            mq.delete();
            m_exp = 1'b0;
        end else begin
            if (wr) void'(mq.pop_front());
            if (s_valid && rdy) begin
                if (s_chan == m_exp) begin
                    mq.push_back(ref_fmt(s_data, frame16, data_size));
                    m_exp = !m_exp;
                end else begin
                    m_err = 1'b1;
                    if (m_drops < DROP_MX) m_drops++;
                end
            end
        end
        @(negedge wclk);
    endtask

    task automatic push(logic [31:0] d, logic ch, logic f16, logic [1:0] dsz);
        s_valid   = 1'b1;
        s_data    = d;
        s_chan    = ch;
        frame16   = f16;
        data_size = dsz;
        tick();
        s_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_ = 1'b0;
        repeat (2) @(negedge wclk);
        #1;
        n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
        n_tests++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
        n_tests++; if (fifo_din !== 32'h0) begin n_fail++; $display("FAIL reset_din: got %h want 0", fifo_din); end
        n_tests++; if (chan_err !== 1'b0) begin n_fail++; $display("FAIL reset_chan_err: got %b want 0", chan_err); end
        n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
        @(negedge wclk);
        rst_ = 1'b1;
        model_reset();
        @(negedge wclk);
    endtask

    task automatic test_basic16();
        frame16 = 1'b1; data_size = 2'b01;
        s_valid = 1'b1; s_chan = 1'b0; s_data = 32'h1234;
        tick();
        s_chan = 1'b1; s_data = 32'hABCD;
        #1;
        n_tests++; if (fifo_wr_en !== 1'b1 || fifo_din !== 32'h00001234) begin
            n_fail++; $display("FAIL basic16_L: got wr=%b din=%h want wr=1 din=00001234", fifo_wr_en, fifo_din); end
        tick();
        s_valid = 1'b0;
        #1;
        n_tests++; if (fifo_wr_en !== 1'b1 || fifo_din !== 32'h0000ABCD) begin
            n_fail++; $display("FAIL basic16_R: got wr=%b din=%h want wr=1 din=0000ABCD", fifo_wr_en, fifo_din); end
        tick(); #1;
        n_tests++; if (fifo_wr_en !== 1'b0 || chan_err !== 1'b0) begin
            n_fail++; $display("FAIL basic16_end: got wr=%b err=%b want wr=0 err=0", fifo_wr_en, chan_err); end
    endtask

    task automatic test_format();
        push(32'h00123456, 1'b0, 1'b0, 2'b10);
        n_tests++; if (fifo_wr_en !== 1'b1 || fifo_din !== 32'h12345600) begin
            n_fail++; $display("FAIL fmt_f32_ds24: got wr=%b din=%h want 12345600", fifo_wr_en, fifo_din); end
        tick();
        push(32'h000000A5, 1'b1, 1'b0, 2'b00);
        n_tests++; if (fifo_wr_en !== 1'b1 || fifo_din !== 32'hA5000000) begin
            n_fail++; $display("FAIL fmt_f32_ds8: got wr=%b din=%h want A5000000", fifo_wr_en, fifo_din); end
        tick();
        push(32'hDEADBEEF, 1'b0, 1'b1, 2'b11);
        n_tests++; if (fifo_wr_en !== 1'b1 || fifo_din !== 32'h0000DEAD) begin
            n_fail++; $display("FAIL fmt_f16_ds32: got wr=%b din=%h want 0000DEAD", fifo_wr_en, fifo_din); end
        tick();
        push(32'hFF345678, 1'b1, 1'b1, 2'b10);
        n_tests++; if (fifo_wr_en !== 1'b1 || fifo_din !== 32'h00003456) begin
            n_fail++; $display("FAIL fmt_f16_ds24: got wr=%b din=%h want 00003456", fifo_wr_en, fifo_din); end
        tick();
        push(32'hFFFFFF5A, 1'b0, 1'b1, 2'b00);
        n_tests++; if (fifo_wr_en !== 1'b1 || fifo_din !== 32'h00005A00) begin
            n_fail++; $display("FAIL fmt_f16_ds8: got wr=%b din=%h want 00005A00", fifo_wr_en, fifo_din); end
        tick();
    endtask

    task automatic test_full();
        logic [31:0] w0, w1, w2;
        w0 = $urandom; w1 = $urandom; w2 = $urandom;
        frame16 = 1'b0; data_size = 2'b11; fifo_full = 1'b1;
        s_valid = 1'b1; s_chan = m_exp; s_data = w0;
        tick();
        s_chan = m_exp; s_data = w1; #1;
        n_tests++; if (s_ready !== 1'b1 || fifo_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL full_one: got rdy=%b wr=%b want rdy=1 wr=0", s_ready, fifo_wr_en); end
        tick();
        s_chan = m_exp; s_data = w2; #1;
        n_tests++; if (s_ready !== 1'b0 || fifo_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL full_two: got rdy=%b wr=%b want rdy=0 wr=0", s_ready, fifo_wr_en); end
        tick(); #1;
        n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL full_hold: got rdy=%b want 0", s_ready); end
        fifo_full = 1'b0; #1;
        n_tests++; if (fifo_wr_en !== 1'b1 || fifo_din !== w0 || s_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_rel0: got wr=%b din=%h rdy=%b want wr=1 din=%h rdy=0", fifo_wr_en, fifo_din, s_ready, w0); end
        tick(); #1;
        n_tests++; if (fifo_wr_en !== 1'b1 || fifo_din !== w1 || s_ready !== 1'b1) begin
            n_fail++; $display("FAIL full_rel1: got wr=%b din=%h rdy=%b want wr=1 din=%h rdy=1", fifo_wr_en, fifo_din, s_ready, w1); end
        tick();
        s_valid = 1'b0; #1;
        n_tests++; if (fifo_wr_en !== 1'b1 || fifo_din !== w2) begin
            n_fail++; $display("FAIL full_rel2: got wr=%b din=%h want wr=1 din=%h", fifo_wr_en, fifo_din, w2); end
        tick(); #1;
        n_tests++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL full_drain: got wr=%b want 0", fifo_wr_en); end
    endtask

    task automatic test_chan();
        logic ch;
        logic [31:0] w;
        ch = m_exp;
        frame16 = 1'b0; data_size = 2'b11;
        s_valid = 1'b1; s_chan = ch; s_data = $urandom;
        tick();
        tick();
        s_valid = 1'b0; #1;
        n_tests++; if (chan_err !== 1'b1 || drop_cnt !== 8'd1) begin
            n_fail++; $display("FAIL chan_drop: got err=%b cnt=%0d want err=1 cnt=1", chan_err, drop_cnt); end
        w = $urandom;
        push(w, ~ch, 1'b0, 2'b11);
        n_tests++; if (fifo_wr_en !== 1'b1 || fifo_din !== w || drop_cnt !== 8'd1) begin
            n_fail++; $display("FAIL chan_next: got wr=%b din=%h cnt=%0d want wr=1 din=%h cnt=1", fifo_wr_en, fifo_din, drop_cnt, w); end
        tick();
        s_valid = 1'b1; s_chan = ~ch; s_data = $urandom;
        repeat (300) tick();
        s_valid = 1'b0; #1;
        n_tests++; if (drop_cnt !== 8'd255 || fifo_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL chan_sat: got cnt=%0d wr=%b want cnt=255 wr=0", drop_cnt, fifo_wr_en); end
    endtask

    task automatic test_stop();
        logic [31:0] w;
        fifo_full = 1'b1;
        push($urandom, m_exp, 1'b0, 2'b11);
        push($urandom, m_exp, 1'b0, 2'b11);
        stop = 1'b1; fifo_full = 1'b0; #1;
        n_tests++; if (fifo_wr_en !== 1'b0 || s_ready !== 1'b0) begin
            n_fail++; $display("FAIL stop_active: got wr=%b rdy=%b want 0 0", fifo_wr_en, s_ready); end
        tick();
        stop = 1'b0; #1;
        n_tests++; if (fifo_wr_en !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++; $display("FAIL stop_flushed: got wr=%b rdy=%b want wr=0 rdy=1", fifo_wr_en, s_ready); end
        n_tests++; if (chan_err !== 1'b1 || drop_cnt !== 8'd255) begin
            n_fail++; $display("FAIL stop_sticky: got err=%b cnt=%0d want 1 255", chan_err, drop_cnt); end
        push($urandom, 1'b1, 1'b0, 2'b11);
        n_tests++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL stop_R_first: got wr=%b want 0", fifo_wr_en); end
        w = $urandom;
        push(w, 1'b0, 1'b0, 2'b11);
        n_tests++; if (fifo_wr_en !== 1'b1 || fifo_din !== w) begin
            n_fail++; $display("FAIL stop_L_first: got wr=%b din=%h want wr=1 din=%h", fifo_wr_en, fifo_din, w); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] w0;
        w0 = $urandom;
        fifo_full = 1'b1;
        push(w0, m_exp, 1'b0, 2'b11);
        push($urandom, m_exp, 1'b0, 2'b11);
        fifo_full = 1'b0; #1;
        n_tests++; if (fifo_wr_en !== 1'b1 || fifo_din !== w0) begin
            n_fail++; $display("FAIL rstmid_pre: got wr=%b din=%h want wr=1 din=%h", fifo_wr_en, fifo_din, w0); end
        rst_ = 1'b0; #1;
        n_tests++; if (fifo_wr_en !== 1'b0 || fifo_din !== 32'h0 || s_ready !== 1'b1 || chan_err !== 1'b0 || drop_cnt !== 8'd0) begin
            n_fail++; $display("FAIL rstmid_async: got wr=%b din=%h rdy=%b err=%b cnt=%0d want 0 0 1 0 0",
                               fifo_wr_en, fifo_din, s_ready, chan_err, drop_cnt); end
        @(negedge wclk);
        rst_ = 1'b1;
        model_reset();
        @(negedge wclk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            s_valid   = ($urandom_range(0, 3) != 0);
            s_chan    = ($urandom_range(0, 9) == 0) ? ~m_exp : m_exp;
            s_data    = $urandom;
            frame16   = $urandom_range(0, 1) != 0;
            data_size = 2'($urandom_range(0, 3));
            fifo_full = ($urandom_range(0, 3) == 0);
            stop      = ($urandom_range(0, 30) == 0);
            #1;
            n_tests++; if (s_ready !== ((mq.size() < 2) && !stop)) begin
                n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, s_ready, (mq.size() < 2) && !stop); end
            n_tests++; if (fifo_wr_en !== ((mq.size() > 0) && !fifo_full && !stop)) begin
                n_fail++; $display("FAIL rnd_wr_en[%0d]: got %b want %b", i, fifo_wr_en, (mq.size() > 0) && !fifo_full && !stop); end
            if (mq.size() > 0) begin
                n_tests++; if (fifo_din !== mq[0]) begin
                    n_fail++; $display("FAIL rnd_din[%0d]: got %h want %h", i, fifo_din, mq[0]); end
            end
            n_tests++; if (chan_err !== m_err || drop_cnt !== CNT_W'(m_drops)) begin
                n_fail++; $display("FAIL rnd_err[%0d]: got err=%b cnt=%0d want err=%b cnt=%0d", i, chan_err, drop_cnt, m_err, m_drops); end
            tick();
        end
        s_valid = 1'b0; stop = 1'b0; fifo_full = 1'b0;
    endtask

`ifdef MONO_DUP_EN
    task automatic test_mono();
        rst_ = 1'b0;
        @(negedge wclk);
        rst_ = 1'b1;
        model_reset();
        @(negedge wclk);
        mono = 1'b1;
        push(32'h7FFF, 1'b1, 1'b1, 2'b01);
        n_tests++; if (fifo_wr_en !== 1'b1 || fifo_din !== 32'h00007FFF || s_ready !== 1'b0) begin
            n_fail++; $display("FAIL mono_w0: got wr=%b din=%h rdy=%b want 1 00007FFF 0", fifo_wr_en, fifo_din, s_ready); end
        tick(); #1;
        n_tests++; if (fifo_wr_en !== 1'b1 || fifo_din !== 32'h00007FFF) begin
            n_fail++; $display("FAIL mono_w1: got wr=%b din=%h want 1 00007FFF", fifo_wr_en, fifo_din); end
        tick(); #1;
        n_tests++; if (fifo_wr_en !== 1'b0 || chan_err !== 1'b0) begin
            n_fail++; $display("FAIL mono_end: got wr=%b err=%b want 0 0", fifo_wr_en, chan_err); end
        mono = 1'b0;
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_basic16();
        test_format();
        test_full();
        test_chan();
        test_stop();
        test_reset_mid();
        test_random();
`ifdef MONO_DUP_EN
        test_mono();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
